intr_pending: RTL

INTR_PENDING -- requirements
Module: intr_pending

---
 rtl/intr_pending.sv | 87 ++++++++
 1 files changed

// File: rtl/intr_pending.sv
// Interrupt pending latch with a presentation handshake for an external
// 4-input priority encoder: pend accumulates requests, P3..P0 hold a masked snapshot.
module intr_pending #(
   parameter int EDGE_MODE = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] irq,
   input  logic [3:0] mask,
   output logic       P3,
   output logic       P2,
   output logic       P1,
   output logic       P0,
   input  logic       O1,
   input  logic       O0,
   output logic       irq_valid,
   input  logic       irq_ack,
   output logic [1:0] ack_idx,
   output logic [3:0] ovr
);

   typedef enum logic [1:0] {IDLE, PRESENT, HOLD} state_t;

   state_t     state, state_nxt;
   logic [3:0] pend, irq_d, snap;
   logic [3:0] new_req, clr, pend_nxt, ovr_nxt, snap_nxt;
   logic [1:0] enc, ack_idx_nxt;

   assign enc     = {O1, O0};
   assign new_req = (EDGE_MODE != 0) ? (irq & ~irq_d) : irq;

   always_comb begin
      state_nxt   = state;
      snap_nxt    = snap;
      clr         = 4'b0000;
      ack_idx_nxt = ack_idx;
      case (state)
         IDLE: begin
            snap_nxt = pend & mask;
            if ((pend & mask) != 4'b0000) state_nxt = PRESENT;
         end
         PRESENT: begin
            if (irq_ack) begin
               clr         = 4'b0001 << enc;
               ack_idx_nxt = enc;
               state_nxt   = HOLD;
            end
         end
         HOLD: begin
            snap_nxt  = pend & mask;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A request landing on the channel being acknowledged survives (set wins)
   // and counts as an overrun, since that channel was still pending.
   assign pend_nxt = (pend & ~clr) | new_req;
   assign ovr_nxt  = (ovr & ~clr) | (new_req & pend);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pend      <= 4'b0000;
         irq_d     <= 4'b0000;
         ovr       <= 4'b0000;
         snap      <= 4'b0000;
         ack_idx   <= 2'b00;
         irq_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         pend      <= pend_nxt;
         irq_d     <= irq;
         ovr       <= ovr_nxt;
         snap      <= snap_nxt;
         ack_idx   <= ack_idx_nxt;
         irq_valid <= (state_nxt == PRESENT);
      end
   end

   assign P3 = snap[3];
   assign P2 = snap[2];
   assign P1 = snap[1];
   assign P0 = snap[0];

endmodule
